stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Parametrised multicycle stage controller: successor to the fixed-stage core FSM.
//  Drives one-hot-low stage enables for NUM_STAGES stages and supports per-instruction stage skipping.
//  Supports variable-latency stages via a ready handshake, a stall timeout and prioritised trap/interrupt entry.
//  Sits between the decode block (skip mask, faults) and the datapath/memory (stage enables, ready).
// PARAMETERS
//  NUM_STAGES         8   number of stages; stage 0 = FETCH, 1 = DECODE, NUM_STAGES-1 = UPDATE_PC (>=3)
//  FAULT_BITS         3   width of fault_num / mem_fault_num
//  TIMEOUT_CYCLES     16  max cycles in one stage without stage_ready; 0 disables timeout
//  TIMEOUT_FAULT_NUM  7   fault_num reported on stall timeout
// PORTS
//  clk                in   1           clock, rising edge
//  reset              in   1           asynchronous, active-high reset
//  stage_ready        in   1           current stage completes this cycle
//  stage_skip         in   NUM_STAGES  per-stage skip mask from decode; used only after DECODE completes
//  illegal_instr_fault in  1           decode/exec illegal-instruction fault, qualified by stage_ready
//  mem_fault_num      in   FAULT_BITS  memory fault code; nonzero = fault, qualified by stage_ready
//  ext_int            in   1           external interrupt pending (level)
//  sw_int             in   1           software interrupt pending (level)
//  stage_active_n     out  NUM_STAGES  one-hot-low active stage
//  control_op         out  2           11 normal, 00 trap, 01 ext int, 10 sw int
//  fault_num          out  FAULT_BITS  cause of last trap
//  instr_retired      out  1           1-cycle pulse when UPDATE_PC completes
// BEHAVIOUR
//  Reset (async, immediate, also mid-instruction): stage_active_n = ~1 (FETCH active); control_op = 11;
//   fault_num = 0; instr_retired = 0; stall counter = 0; pending-fault latch cleared.
//  Stage state: exactly one stage active every cycle. The stage advances only on a clk edge with stage_ready=1.
//   Each active stage lasts >=1 cycle; there is no idle state.
//  Next stage from FETCH = DECODE.
//  Next stage from stage s >= DECODE = lowest index > s with stage_skip=0.
//   FETCH, DECODE and UPDATE_PC are never skipped: stage_skip bits 0, 1 and NUM_STAGES-1 are ignored.
//  UPDATE_PC with stage_ready: wrap to FETCH, instr_retired=1 for that one cycle, and new control_op chosen.
//   Priority for the new control_op: latched fault -> 00; else ext_int -> 01; else sw_int -> 10; else 11.
//   Interrupts are sampled only at this edge.
//  Faults (only while control_op=11; ignored during trap/interrupt entry):
//   - Sources: mem_fault_num!=0 in any stage, or illegal_instr_fault in stage >= DECODE, each with stage_ready.
//   - Effect: latch fault_num and jump directly to UPDATE_PC at the next edge, ignoring skip.
//   - Same-cycle mem fault and illegal fault: the mem code wins.
//   - Only the first fault per instruction is latched.
//  fault_num holds its value until the next fault latch; the latch flag clears at wrap.
//  Stall timeout: counter increments on each cycle with stage_ready=0 and clears on stage advance.
//   - On the edge where the counter would reach TIMEOUT_CYCLES: act as a fault with fault_num = TIMEOUT_FAULT_NUM.
//   - If the stall occurs in UPDATE_PC: wrap to FETCH without instr_retired.
//   - Counter width: $clog2(TIMEOUT_CYCLES+1).
//  Outputs are registered, with zero combinational paths from inputs to outputs.
//   stage_active_n changes only on a clk edge or reset.
// TESTING
//  1. NUM_STAGES=8, skip=0, ready=1 after reset -> stage_active_n FE,FD,FB,..,7F,FE; retired every 8th cycle; op=11.
//  2. stage_skip=8'b0011_0100 -> stages 0,1,3,6,7; retired every 5 cycles.
//  3. ready low 3 cycles in stage 4 -> stage 4 held 4 cycles; no timeout; sequence resumes at stage 5.
//  4. mem_fault_num=5 with ready in stage 4 -> stage 7 next; after wrap op=00, fault_num=5.
//     Next instr op=11 and fault_num stays 5.
//  5. ext_int=sw_int=1 at wrap, no fault -> op=01. Repeat with a fault in the same instr -> op=00.
//     ext_int=0, sw_int=1 -> op=10.
//  6. ready stuck 0 in stage 2 -> after 16 cycles jump to stage 7, fault_num=7. Then reset high in stage 5
//     -> stage_active_n=FE immediately and op=11.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between decode/datapath and the stage sequencer.
// The sequencer uses the slave side; decode/datapath (or a bench) drives the master side.
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 8,
    parameter int FAULT_BITS = 3
);
    logic                  stage_ready;
    logic [NUM_STAGES-1:0] stage_skip;
    logic                  illegal_instr_fault;
    logic [FAULT_BITS-1:0] mem_fault_num;
    logic                  ext_int;
    logic                  sw_int;
    logic [NUM_STAGES-1:0] stage_active_n;
    logic [1:0]            control_op;
    logic [FAULT_BITS-1:0] fault_num;
    logic                  instr_retired;

    modport master (
        output stage_ready, stage_skip, illegal_instr_fault, mem_fault_num, ext_int, sw_int,
        input  stage_active_n, control_op, fault_num, instr_retired
    );

    modport slave (
        input  stage_ready, stage_skip, illegal_instr_fault, mem_fault_num, ext_int, sw_int,
        output stage_active_n, control_op, fault_num, instr_retired
    );
endinterface

// File: rtl/stage_sequencer.sv
// Parametrised multicycle stage controller: one-hot-low stage enables, per-instruction
// stage skipping, ready handshake with stall timeout, and prioritised trap/interrupt entry.
module stage_sequencer #(
    parameter int NUM_STAGES        = 8,
    parameter int FAULT_BITS        = 3,
    parameter int TIMEOUT_CYCLES    = 16,
    parameter int TIMEOUT_FAULT_NUM = 7,
    parameter int ILLEGAL_FAULT_NUM = 2   // code latched for an illegal-instruction fault
) (
    input  logic             clk,
    input  logic             reset,
    stage_sequencer_if.slave sif
);
    localparam int SW = $clog2(NUM_STAGES);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    // FETCH, DECODE and UPDATE_PC can never be skipped
    localparam logic [NUM_STAGES-1:0] SKIP_MASK =
        ~(NUM_STAGES'(3) | (NUM_STAGES'(1) << (NUM_STAGES - 1)));

    typedef enum logic [1:0] {
        OP_TRAP   = 2'b00,
        OP_EXT    = 2'b01,
        OP_SW     = 2'b10,
        OP_NORMAL = 2'b11
    } op_e;

    logic [SW-1:0]         r_stage, w_stage, w_seq_next;
    logic [NUM_STAGES-1:0] r_active_n, w_skip;
    op_e                   r_op, w_op;
    logic [FAULT_BITS-1:0] r_fault_num, w_fault_num;
    logic                  r_retired, w_retired;
    logic                  r_latched, w_latched;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic                  w_accept, w_mem_flt, w_ill_flt, w_timeout, w_take;

    always_comb w_skip = sif.stage_skip & SKIP_MASK;

    // Lowest non-skipped stage above the current one; UPDATE_PC is the fallback.
    always_comb begin
        w_seq_next = LAST;
        if (r_stage == '0)
            w_seq_next = SW'(1);
        else
            for (int i = NUM_STAGES - 2; i >= 2; i--)
                if (i > int'(r_stage) && !w_skip[i])
                    w_seq_next = SW'(i);
    end

    always_comb begin
        w_accept  = (r_op == OP_NORMAL) && !r_latched;
        w_mem_flt = sif.stage_ready && (sif.mem_fault_num != '0);
        w_ill_flt = sif.stage_ready && sif.illegal_instr_fault && (r_stage != '0);
        w_timeout = (TIMEOUT_CYCLES > 0) && !sif.stage_ready && (r_cnt == CNT_LIMIT);
        w_take    = w_accept && (w_timeout || w_mem_flt || w_ill_flt);
    end

    always_comb begin
        w_stage     = r_stage;
        w_op        = r_op;
        w_fault_num = r_fault_num;
        w_retired   = 1'b0;
        w_latched   = r_latched || w_take;
        w_cnt       = r_cnt + 1'b1;
        if (w_take)
            w_fault_num = w_timeout ? FAULT_BITS'(TIMEOUT_FAULT_NUM) :
                          w_mem_flt ? sif.mem_fault_num : FAULT_BITS'(ILLEGAL_FAULT_NUM);
        // A timeout forces progress even when the fault itself is not recorded.
        if (sif.stage_ready || w_timeout) begin
            w_cnt = '0;
            if (r_stage == LAST) begin
                w_stage   = '0;
                w_retired = sif.stage_ready;
                w_latched = 1'b0;
                if (r_latched || w_take) w_op = OP_TRAP;
                else if (sif.ext_int)    w_op = OP_EXT;
                else if (sif.sw_int)     w_op = OP_SW;
                else                     w_op = OP_NORMAL;
            end else if (w_take || w_timeout) begin
                w_stage = LAST;
            end else begin
                w_stage = w_seq_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage     <= '0;
            r_active_n  <= ~NUM_STAGES'(1);
            r_op        <= OP_NORMAL;
            r_fault_num <= '0;
            r_retired   <= 1'b0;
            r_latched   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_stage     <= w_stage;
            r_active_n  <= ~(NUM_STAGES'(1) << w_stage);
            r_op        <= w_op;
            r_fault_num <= w_fault_num;
            r_retired   <= w_retired;
            r_latched   <= w_latched;
            r_cnt       <= w_cnt;
        end
    end

    assign sif.stage_active_n = r_active_n;
    assign sif.control_op     = r_op;
    assign sif.fault_num      = r_fault_num;
    assign sif.instr_retired  = r_retired;
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the sequencing rules.
module tb_stage_sequencer;
    localparam int N   = 8;
    localparam int FB  = 3;
    localparam int TO  = 16;
    localparam int TFN = 7;
    localparam int ILL = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int m_stage, m_op, m_fnum, m_cnt;
    bit m_latched, m_ret;

    stage_sequencer_if #(.NUM_STAGES(N), .FAULT_BITS(FB)) sif ();

    stage_sequencer #(
        .NUM_STAGES(N), .FAULT_BITS(FB), .TIMEOUT_CYCLES(TO),
        .TIMEOUT_FAULT_NUM(TFN), .ILLEGAL_FAULT_NUM(ILL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sif  (sif.slave)
    );

    always #5 clk = ~clk;

    function automatic int next_stage(int s, logic [N-1:0] sk);
        if (s == 0) return 1;
        for (int i = s + 1; i < N - 1; i++)
            if (!sk[i]) return i;
        return N - 1;
    endfunction

    function automatic logic [13:0] m_vec();
        logic [N-1:0] a;
        a = '1;
        a[m_stage] = 1'b0;
        return {a, 2'(m_op), 3'(m_fnum), m_ret};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {sif.stage_active_n, sif.control_op, sif.fault_num, sif.instr_retired};
    endfunction

    task automatic model_reset();
        m_stage = 0; m_op = 3; m_fnum = 0; m_cnt = 0; m_latched = 0; m_ret = 0;
    endtask

    task automatic model_edge();
        bit tout, fault;
        int code;
        tout  = (TO > 0) && !sif.stage_ready && (m_cnt + 1 == TO);
        fault = 0;
        code  = 0;
        if (m_op == 3 && !m_latched) begin
            if (tout) begin fault = 1; code = TFN; end
            else if (sif.stage_ready && sif.mem_fault_num != 0) begin fault = 1; code = int'(sif.mem_fault_num); end
            else if (sif.stage_ready && sif.illegal_instr_fault && m_stage >= 1) begin fault = 1; code = ILL; end
        end
        if (fault) begin m_fnum = code; m_latched = 1; end
        m_ret = 0;
        if (!sif.stage_ready && !tout) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
            if (m_stage == N - 1) begin
                m_ret   = sif.stage_ready;
                m_stage = 0;
                m_op    = m_latched ? 0 : sif.ext_int ? 1 : sif.sw_int ? 2 : 3;
                m_latched = 0;
            end else if (fault || tout) begin
                m_stage = N - 1;
            end else begin
                m_stage = next_stage(m_stage, sif.stage_skip);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sif.stage_ready = 1'b1; sif.stage_skip = '0; sif.illegal_instr_fault = 1'b0;
        sif.mem_fault_num = '0; sif.ext_int = 1'b0; sif.sw_int = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic advance_to(int t);
        sif.stage_ready = 1'b1;
        for (int k = 0; k < 2 * N && m_stage != t; k++) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== m_vec()) begin
            errors++; $display("FAIL reset_async: got %h expected %h", dut_vec(), m_vec());
        end
        @(negedge clk);
        checks++;
        if (sif.stage_active_n !== 8'hFE || sif.control_op !== 2'b11) begin
            errors++; $display("FAIL reset_held: got %h/%b expected fe/11", sif.stage_active_n, sif.control_op);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        logic [N-1:0] e;
        int rets = 0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step();
            e = '1;
            e[(k + 1) % N] = 1'b0;
            rets += int'(sif.instr_retired);
            checks++;
            if (dut_vec() !== m_vec() || sif.stage_active_n !== e) begin
                errors++; $display("FAIL seq_cyc%0d: got %h expected %h", k, dut_vec(), m_vec());
            end
        end
        checks++;
        if (rets != 2) begin errors++; $display("FAIL seq_retired_count: got %0d expected 2", rets); end
    endtask

    task automatic test_skip();
        int rets = 0;
        do_reset();
        sif.stage_skip = 8'b0011_0100;
        for (int k = 0; k < 15; k++) begin
            step();
            rets += int'(sif.instr_retired);
            checks++;
            if (dut_vec() !== m_vec()) begin
                errors++; $display("FAIL skip_cyc%0d: got %h expected %h", k, dut_vec(), m_vec());
            end
        end
        checks++;
        if (rets != 3) begin errors++; $display("FAIL skip_retired_count: got %0d expected 3", rets); end
        sif.stage_skip = '0;
    endtask

    task automatic test_stall();
        do_reset();
        advance_to(4);
        sif.stage_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dut_vec() !== m_vec() || sif.stage_active_n !== 8'hEF) begin
                errors++; $display("FAIL stall_hold%0d: got %h expected %h", k, dut_vec(), m_vec());
            end
        end
        sif.stage_ready = 1'b1;
        step();
        checks++;
        if (sif.stage_active_n !== 8'hDF || sif.control_op !== 2'b11) begin
            errors++; $display("FAIL stall_resume: got %h/%b expected df/11", sif.stage_active_n, sif.control_op);
        end
    endtask

    task automatic test_fault();
        do_reset();
        advance_to(4);
        sif.mem_fault_num = 3'd5;
        step();
        sif.mem_fault_num = '0;
        checks++;
        if (dut_vec() !== m_vec() || sif.stage_active_n !== 8'h7F || sif.fault_num !== 3'd5) begin
            errors++; $display("FAIL fault_jump: got %h expected %h", dut_vec(), m_vec());
        end
        step();
        checks++;
        if (sif.control_op !== 2'b00 || sif.fault_num !== 3'd5 || sif.stage_active_n !== 8'hFE) begin
            errors++; $display("FAIL fault_trap_entry: got %h expected op00 fnum5 fe", dut_vec());
        end
        advance_to(N - 1);
        step();
        checks++;
        if (sif.control_op !== 2'b11 || sif.fault_num !== 3'd5) begin
            errors++; $display("FAIL fault_hold: got op %b fnum %0d expected 11/5", sif.control_op, sif.fault_num);
        end
        advance_to(2);
        sif.mem_fault_num = 3'd3;
        sif.illegal_instr_fault = 1'b1;
        step();
        sif.illegal_instr_fault = 1'b0;
        sif.mem_fault_num = 3'd6;
        checks++;
        if (sif.fault_num !== 3'd3 || sif.stage_active_n !== 8'h7F) begin
            errors++; $display("FAIL fault_mem_wins: got fnum %0d stage %h expected 3/7f", sif.fault_num, sif.stage_active_n);
        end
        step();
        sif.mem_fault_num = '0;
        checks++;
        if (dut_vec() !== m_vec() || sif.fault_num !== 3'd3 || sif.control_op !== 2'b00) begin
            errors++; $display("FAIL fault_first_only: got %h expected %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_interrupts();
        do_reset();
        sif.ext_int = 1'b1; sif.sw_int = 1'b1;
        advance_to(N - 1);
        step();
        checks++;
        if (sif.control_op !== 2'b01 || sif.instr_retired !== 1'b1) begin
            errors++; $display("FAIL int_ext: got op %b ret %b expected 01/1", sif.control_op, sif.instr_retired);
        end
        sif.ext_int = 1'b0; sif.sw_int = 1'b0;
        advance_to(N - 1);
        step();
        checks++;
        if (sif.control_op !== 2'b11) begin errors++; $display("FAIL int_none: got %b expected 11", sif.control_op); end
        sif.ext_int = 1'b1; sif.sw_int = 1'b1;
        advance_to(3);
        sif.illegal_instr_fault = 1'b1;
        step();
        sif.illegal_instr_fault = 1'b0;
        step();
        checks++;
        if (sif.control_op !== 2'b00 || sif.fault_num !== 3'(ILL)) begin
            errors++; $display("FAIL int_fault_prio: got op %b fnum %0d expected 00/%0d", sif.control_op, sif.fault_num, ILL);
        end
        sif.ext_int = 1'b0;
        advance_to(N - 1);
        step();
        checks++;
        if (dut_vec() !== m_vec() || sif.control_op !== 2'b10) begin
            errors++; $display("FAIL int_sw: got %h expected %h", dut_vec(), m_vec());
        end
        sif.sw_int = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        advance_to(2);
        sif.stage_ready = 1'b0;
        for (int k = 0; k < TO - 1; k++) step();
        checks++;
        if (dut_vec() !== m_vec() || sif.stage_active_n !== 8'hFB) begin
            errors++; $display("FAIL timeout_not_yet: got %h expected %h", dut_vec(), m_vec());
        end
        step();
        checks++;
        if (sif.stage_active_n !== 8'h7F || sif.fault_num !== 3'(TFN)) begin
            errors++; $display("FAIL timeout_jump: got %h fnum %0d expected 7f/%0d", sif.stage_active_n, sif.fault_num, TFN);
        end
        advance_to(5);
        checks++;
        if (dut_vec() !== m_vec() || sif.control_op !== 2'b00) begin
            errors++; $display("FAIL timeout_trap: got %h expected %h", dut_vec(), m_vec());
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (sif.stage_active_n !== 8'hFE || sif.control_op !== 2'b11 || sif.instr_retired !== 1'b0) begin
            errors++; $display("FAIL reset_midinstr: got %h expected %h", dut_vec(), m_vec());
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_timeout_update_pc();
        do_reset();
        advance_to(N - 1);
        sif.stage_ready = 1'b0;
        for (int k = 0; k < TO; k++) step();
        checks++;
        if (dut_vec() !== m_vec() || sif.stage_active_n !== 8'hFE || sif.instr_retired !== 1'b0
            || sif.control_op !== 2'b00 || sif.fault_num !== 3'(TFN)) begin
            errors++; $display("FAIL timeout_updpc: got %h expected %h", dut_vec(), m_vec());
        end
        sif.stage_ready = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            sif.stage_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) sif.stage_skip = N'($urandom);
            sif.ext_int = ($urandom_range(0, 3) == 0);
            sif.sw_int  = ($urandom_range(0, 2) == 0);
            sif.mem_fault_num = '0;
            sif.illegal_instr_fault = 1'b0;
            if (m_stage != N - 1) begin
                if ($urandom_range(0, 19) == 0) sif.mem_fault_num = 3'($urandom_range(1, 7));
                sif.illegal_instr_fault = ($urandom_range(0, 14) == 0);
            end
            step();
            checks++;
            if (dut_vec() !== m_vec()) begin
                errors++; $display("FAIL random_cyc%0d: got %h expected %h", k, dut_vec(), m_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_skip();
        test_stall();
        test_fault();
        test_interrupts();
        test_timeout();
        test_timeout_update_pc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
